// File: rtl/pc_fetch_gen.sv
// rtl/pc_fetch_gen.sv - fetch-stage PC generator with increment, redirect, stall and fetch handshake; optional PC_MISALIGN_CHK_EN
module pc_fetch_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            if_ready,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            redir_first,
    output logic            misalign_err
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_trap_q, pend_trap_d;
    logic            redir_q, redir_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] trap_addr, br_addr, redir_tgt, merged_tgt;
    logic            br_take, mis_flag, redirect, merged_trap;

    assign trap_addr = trap_target & ALIGN_MASK;
    assign br_addr   = br_target & ALIGN_MASK;

`ifdef PC_MISALIGN_CHK_EN
    logic br_misaligned;
    assign br_misaligned = |(br_target & ~ALIGN_MASK);
    // A misaligned branch is dropped; a trap in the same cycle still wins and suppresses the error.
    assign br_take  = br_valid & ~br_misaligned;
    assign mis_flag = br_valid & br_misaligned & ~trap_valid;
`else
    assign br_take  = br_valid;
    assign mis_flag = 1'b0;
`endif

    assign redirect  = trap_valid | br_take;
    assign redir_tgt = trap_valid ? trap_addr : br_addr;

    // Pending redirect merge: a trap always replaces, a branch never replaces a pending trap.
    assign merged_tgt  = trap_valid ? trap_addr :
                         (br_take & ~pend_trap_q) ? br_addr : pend_q;
    assign merged_trap = trap_valid | pend_trap_q;

    assign pc           = pc_q;
    assign pc_plus_inc  = pc_q + XLEN'(INC);
    assign redir_first  = redir_q;
    assign misalign_err = mis_q;

    // Next-state and fetch request decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_trap_d = pend_trap_q;
        redir_d     = 1'b0;
        mis_d       = mis_flag;
        pc_valid    = 1'b0;
        case (state_q)
            BOOT, RUN: begin
                pc_valid = (state_q == RUN) & ~stall;
                state_d  = RUN;
                if (stall) begin
                    if (redirect) begin
                        pend_d      = merged_tgt;
                        pend_trap_d = merged_trap;
                        state_d     = HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding request is dropped even if it was accepted this cycle.
                    pc_d    = redir_tgt;
                    redir_d = 1'b1;
                end else if (pc_valid & if_ready) begin
                    pc_d = pc_plus_inc;
                end
            end
            HOLD: begin
                pend_d      = merged_tgt;
                pend_trap_d = merged_trap;
                if (!stall) begin
                    pc_d        = merged_tgt;
                    redir_d     = 1'b1;
                    pend_trap_d = 1'b0;
                    state_d     = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and datapath registers; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pend_q      <= '0;
            pend_trap_q <= 1'b0;
            redir_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
            redir_q     <= redir_d;
            mis_q       <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb/tb_pc_fetch_gen.sv - self-checking bench for pc_fetch_gen against a behavioural model
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_plus_inc;
    logic        redir_first;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

`ifdef PC_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    pc_fetch_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
        .br_valid(br_valid), .br_target(br_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .pc(pc), .pc_valid(pc_valid), .pc_plus_inc(pc_plus_inc),
        .redir_first(redir_first), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: fetch address plus a "booting" flag and an optional parked redirect.
    logic [31:0] m_pc;
    bit          m_booting, m_pending, m_pend_trap, m_redir, m_mis;
    logic [31:0] m_pend_addr;

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a - (a % 32'd4);
    endfunction

    function automatic logic [31:0] add4(input logic [31:0] a);
        longint unsigned s;
        s = (longint'(a) + 4) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    always @(posedge clk) begin
        bit          valid, br_ok, new_redir;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_booting = 1; m_pending = 0; m_pend_trap = 0;
            m_redir = 0; m_mis = 0; m_pend_addr = 0;
        end else begin
            valid     = !m_booting && !m_pending && !stall;
            br_ok     = br_valid && (!CHK || (br_target % 32'd4) == 0);
            m_mis     = CHK && br_valid && (br_target % 32'd4) != 0 && !trap_valid;
            new_redir = trap_valid || br_ok;
            tgt       = trap_valid ? align4(trap_target) : align4(br_target);
            m_redir   = 0;
            if (m_pending) begin
                if (trap_valid) begin
                    m_pend_addr = align4(trap_target); m_pend_trap = 1;
                end else if (br_ok && !m_pend_trap) begin
                    m_pend_addr = align4(br_target);
                end
                if (!stall) begin
                    m_pc = m_pend_addr; m_pending = 0; m_pend_trap = 0; m_redir = 1;
                end
            end else if (stall) begin
                if (new_redir) begin
                    m_pending = 1; m_pend_addr = tgt; m_pend_trap = trap_valid;
                end
            end else if (new_redir) begin
                m_pc = tgt; m_redir = 1;
            end else if (valid && if_ready) begin
                m_pc = add4(m_pc);
            end
            m_booting = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("pc_valid", {31'b0, pc_valid}, {31'b0, !m_booting && !m_pending && !stall});
            chk("pc_plus_inc", pc_plus_inc, add4(m_pc));
            chk("redir_first", {31'b0, redir_first}, {31'b0, m_redir});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        br_valid   = 1'b0;
        trap_valid = 1'b0;
    endtask

    initial begin
        // 1: reset, boot cycle, sequential fetch
        rst = 1; if_ready = 1;
        step(); chk_en = 1;
        step();
        rst = 0;
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", {31'b0, pc_valid}, 32'h0);
        step();
        chk("run_pc0", pc, 32'h0);
        chk("run_valid", {31'b0, pc_valid}, 32'h1);
        step(); step(); step();
        chk("seq_pc_c", pc, 32'hC);
        step();
        // 2: fetch port back-pressure
        if_ready = 0;
        step(); step(); step();
        chk("hold_pc", pc, 32'h10);
        chk("hold_valid", {31'b0, pc_valid}, 32'h1);
        if_ready = 1;
        step();
        chk("after_hold", pc, 32'h14);
        // 3: trap beats branch
        br_valid = 1; br_target = 32'h100; trap_valid = 1; trap_target = 32'h800;
        step();
        chk("trap_prio_pc", pc, 32'h800);
        chk("trap_prio_rf", {31'b0, redir_first}, 32'h1);
        // 4: redirects while stalled
        stall = 1; br_valid = 1; br_target = 32'h200;
        step();
        chk("stall_valid", {31'b0, pc_valid}, 32'h0);
        trap_valid = 1; trap_target = 32'h400;
        step(); step(); step();
        stall = 0;
        step();
        chk("unstall_pc", pc, 32'h400);
        chk("unstall_rf", {31'b0, redir_first}, 32'h1);
        // 5: wrap-around, then reset while holding a redirect
        br_valid = 1; br_target = 32'hFFFF_FFFC;
        step();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc, 32'h0);
        stall = 1; br_valid = 1; br_target = 32'h300;
        step();
        rst = 1;
        step();
        rst = 0; stall = 0; if_ready = 0;
        step(); step();
        chk("rst_drop_pend", pc, 32'h0);
        // 6: misaligned branch target
        if_ready = 1; br_valid = 1; br_target = 32'h102;
        step();
        if (CHK) begin
            chk("mis_pc", pc, 32'h4);
            chk("mis_err", {31'b0, misalign_err}, 32'h1);
        end else begin
            chk("mis_pc", pc, 32'h100);
            chk("mis_err", {31'b0, misalign_err}, 32'h0);
        end
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            if_ready   = ($urandom_range(0, 3) != 0);
            br_valid   = ($urandom_range(0, 7) == 0);
            br_target  = $urandom();
            if ($urandom_range(0, 1) == 0) br_target[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) br_target = 32'hFFFF_FFF0 | (br_target & 32'hC);
            trap_valid  = ($urandom_range(0, 15) == 0);
            trap_target = $urandom();
            @(posedge clk);
            #1;
        end
        rst = 0; br_valid = 0; trap_valid = 0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
